packet_transmitter: RTL and testbench
=====================================

# packet_transmitter

Serializes the correlator's accumulated `pulses` payload onto a UART line for the host. It sits directly downstream of the correlator. On `start` it snapshots the payload bus and frames it with a header carrying a sequence number, plus a checksum footer. It then sends the packet as 8N1 bytes, either raw binary or ASCII hex.

## Interface
- `PAYLOAD_SIZE`, 96: width of `pulses` in bits; must be a multiple of 8.
- `CLK_FREQUENCY`, 10000000: `clk` frequency in Hz.
- `BAUD_RATE`, 57600: line rate.
- `BINARY`, 0: 0 selects ASCII hex framing; 1 selects raw bytes.
- localparam `BAUD_CYCLES` = CLK_FREQUENCY/BAUD_RATE (integer divide, ≥2); `PACKET_BYTES` = 8 + PAYLOAD_SIZE/8 + 8.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `pulses` in PAYLOAD_SIZE: correlator payload; snapshotted on `start`.
- `start` in 1: request to send one packet; sampled at a rising edge.
- `tx` out 1: UART line, idle high.
- `busy` out 1: high while a packet is in flight.
- `done` out 1: one-cycle pulse when a packet completes.
- `dropped` out 1: one-cycle pulse when `start` arrives while `busy`.

## Operation
- Packet byte order is MS byte first throughout:
  - header `{32'hA55AC3C3, seq[31:0]}`
  - snapshot payload
  - footer `{56'h0, csum[7:0]}`
- `csum` is the mod-256 sum of the payload bytes only.
- `seq` resets to 0 and increments (wrapping) after each completed packet.
- State machine: IDLE → SEND → IDLE.
- IDLE: `tx`=1, `busy`=0.
  - When `start`=1, latch `pulses` and `seq` into shadow registers, clear `csum`, byte index = 0, go SEND.
- SEND: feed bytes to the byte serializer back-to-back.
  - `BINARY`=1: each byte is sent raw.
  - `BINARY`=0: each byte becomes two ASCII chars, high nibble first ('0'–'9' = 0x30–0x39, 'A'–'F' = 0x41–0x46). After the last byte, send 0x0D then 0x0A.
  - After the last character's stop bit: pulse `done`, increment `seq`, go IDLE.
- UART frame: start bit 0, 8 data bits LSB first, one stop bit 1. Each bit lasts exactly `BAUD_CYCLES` clocks. There is no idle gap between characters.
- `start` while `busy`=1 is ignored for the stream and pulses `dropped` in the next cycle.
- Changes on `pulses` during SEND have no effect.
- Reset asserted at any point:
  - immediately `tx`=1, `busy`=0, `done`=0, `dropped`=0, `seq`=0;
  - state IDLE, shadow and `csum` cleared;
  - any partial frame is abandoned.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `dropped`=0.
- `start` sampled high at edge N:
  - `busy`=1 and `tx`=0 (start bit) from cycle N+1;
  - every bit edge falls at N+1 + k·`BAUD_CYCLES`.
- Packet duration in clocks:
  - binary: `PACKET_BYTES`·10·`BAUD_CYCLES`;
  - ASCII: (2·`PACKET_BYTES`+2)·10·`BAUD_CYCLES`.
- Completion: in the cycle after the last stop bit ends, `done`=1 and `busy`=0.
- A `start` in that same cycle is accepted and produces no `dropped` pulse.
- `csum` accumulates as each payload byte is loaded into the serializer. It is final before the footer's last byte is loaded.

## Structure
- Shared package `ahp_link_pkg` holds:
  - `SYNC_WORD` = 32'hA55AC3C3;
  - `CHAR_CR` and `CHAR_LF`;
  - the `nibble_to_ascii` function;
  - the `BAUD_CYCLES` computation helper.
- Sub-module `uart_tx_byte`: an 8N1 serializer with parameter `BAUD_CYCLES`.
  - Ports: `clk`, `reset`, `data[7:0]`, `valid`, `ready`, `tx`.
  - `ready` is high in the final cycle of the stop bit, allowing back-to-back characters.
- `packet_transmitter` owns the shadow register, byte/nibble indexing, `seq`, `csum` and the FSM.

## Test plan
Use `PAYLOAD_SIZE`=16, `CLK_FREQUENCY`=8, `BAUD_RATE`=1 (`BAUD_CYCLES`=8) for all scenarios.
- Binary, `pulses`=16'h1234, pulse `start`:
  - bytes A5 5A C3 C3 00 00 00 00 12 34 00 00 00 00 00 00 00 46;
  - `done` exactly 1440 cycles after `tx` first falls.
- ASCII, same stimulus:
  - 38 chars "A55AC3C3000000001234" + "0000000000000046" + 0x0D 0x0A;
  - duration 3040 cycles.
- Second packet after completion: header bytes end 00 00 00 01. A `start` asserted in the `done` cycle begins the start bit on the next cycle.
- Assert `start` and change `pulses` to 16'hBEEF mid-packet:
  - `dropped` pulses once;
  - the transmitted stream is unchanged;
  - `busy` stays high.
- `pulses`=16'hFFFF: checksum byte is 0xFE.
- Drive `reset` low in the middle of a data bit:
  - `tx`=1 and `busy`=0 in the same cycle;
  - after release, the next packet carries `seq` 0.

Source files
------------

// File: rtl/ahp_link_pkg.sv
// ahp_link_pkg: shared constants, FSM state type and helpers for the host link.
package ahp_link_pkg;
    localparam logic [31:0] SYNC_WORD = 32'hA55AC3C3;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic {IDLE, SEND} tx_state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic int baud_cycles(input int clk_frequency, input int baud_rate);
        return clk_frequency / baud_rate;
    endfunction
endpackage

// File: rtl/packet_transmitter_if.sv
// packet_transmitter_if: correlator-side request and UART-side status bundle.
interface packet_transmitter_if #(
    parameter int PAYLOAD_SIZE = 96
);
    logic [PAYLOAD_SIZE-1:0] pulses;
    logic start;
    logic tx;
    logic busy;
    logic done;
    logic dropped;

    modport master (output pulses, start, input tx, busy, done, dropped);
    modport slave (input pulses, start, output tx, busy, done, dropped);
endinterface

// File: rtl/packet_transmitter_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; ready rises in the last stop-bit cycle so characters chain gaplessly.
module uart_tx_byte #(
    parameter int BAUD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    localparam int BW = (BAUD_CYCLES > 2) ? $clog2(BAUD_CYCLES) : 1;

    logic [BW-1:0] baud_cnt;
    logic [3:0] bit_cnt;
    logic [9:0] frame;
    logic active;
    logic baud_end;

    assign baud_end = baud_cnt == BW'(BAUD_CYCLES - 1);
    assign ready = !active || (bit_cnt == 4'd9 && baud_end);
    assign tx = !active || frame[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            frame <= '1;
            bit_cnt <= '0;
            baud_cnt <= '0;
        end else if (valid && ready) begin
            active <= 1'b1;
            frame <= {1'b1, data, 1'b0};
            bit_cnt <= '0;
            baud_cnt <= '0;
        end else if (active) begin
            if (baud_end) begin
                baud_cnt <= '0;
                bit_cnt <= bit_cnt + 4'd1;
                frame <= {1'b1, frame[9:1]};
                if (bit_cnt == 4'd9) active <= 1'b0;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end
endmodule

// File: rtl/packet_transmitter.sv
// packet_transmitter: frames a snapshotted payload with header/checksum and streams it as binary or ASCII-hex UART.
module packet_transmitter
    import ahp_link_pkg::*;
#(
    parameter int PAYLOAD_SIZE  = 96,
    parameter int CLK_FREQUENCY = 10000000,
    parameter int BAUD_RATE     = 57600,
    parameter bit BINARY        = 1'b0
) (
    input logic clk,
    input logic reset,
    packet_transmitter_if.slave link
);
    localparam int BAUD_CYCLES = baud_cycles(CLK_FREQUENCY, BAUD_RATE);
    localparam int PAY_BYTES = PAYLOAD_SIZE / 8;
    localparam int PACKET_BYTES = 8 + PAY_BYTES + 8;
    localparam int IW = $clog2(PACKET_BYTES + 1);
    localparam logic [IW-1:0] LAST_BYTE = IW'(PACKET_BYTES - 1);
    localparam logic [IW-1:0] EOL_IDX = IW'(PACKET_BYTES);
    localparam logic [IW-1:0] PAY_FIRST = IW'(8);
    localparam logic [IW-1:0] PAY_END = IW'(8 + PAY_BYTES);

    tx_state_t state, state_nxt;
    logic [PAYLOAD_SIZE-1:0] pay_sh;
    logic [31:0] seq, seq_sh;
    logic [7:0] csum, cur_byte, cur_char;
    logic [IW-1:0] idx;
    logic nib, fin, valid, ready, last_char, finish;
    logic [8*PACKET_BYTES-1:0] pkt;

    // byte 0 is the constant sync byte, so the mux is valid in IDLE before the shadow loads
    assign pkt = {SYNC_WORD, seq_sh, pay_sh, 56'h0, csum};

    always_comb begin
        cur_byte = '0;
        for (int b = 0; b < PACKET_BYTES; b++)
            if (idx == IW'(b)) cur_byte = pkt[8*(PACKET_BYTES-1-b) +: 8];
    end

    assign cur_char = BINARY ? cur_byte :
                      idx == EOL_IDX ? (nib ? CHAR_LF : CHAR_CR) :
                      nibble_to_ascii(nib ? cur_byte[3:0] : cur_byte[7:4]);
    assign last_char = BINARY ? idx == LAST_BYTE : idx == EOL_IDX && nib;
    assign finish = state == SEND && fin && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE && link.start) ? SEND : finish ? IDLE : state;
    end

    always_comb begin
        link.busy = state == SEND;
        valid = state == IDLE ? link.start : !fin;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pay_sh <= '0;
            seq <= '0;
            seq_sh <= '0;
            csum <= '0;
            idx <= '0;
            nib <= 1'b0;
            fin <= 1'b0;
            link.done <= 1'b0;
            link.dropped <= 1'b0;
        end else begin
            link.done <= finish;
            link.dropped <= state == SEND && link.start;
            if (state == IDLE && link.start) begin
                pay_sh <= link.pulses;
                seq_sh <= seq;
                csum <= '0;
            end
            if (valid && ready) begin
                if (idx >= PAY_FIRST && idx < PAY_END && (BINARY || nib)) csum <= csum + cur_byte;
                if (last_char) begin
                    fin <= 1'b1;
                end else if (BINARY || nib) begin
                    idx <= idx + IW'(1);
                    nib <= 1'b0;
                end else begin
                    nib <= 1'b1;
                end
            end
            if (finish) begin
                idx <= '0;
                nib <= 1'b0;
                fin <= 1'b0;
                seq <= seq + 32'd1;
            end
        end
    end

    uart_tx_byte #(.BAUD_CYCLES(BAUD_CYCLES)) u_uart (
        .clk(clk),
        .reset(reset),
        .data(cur_char),
        .valid(valid),
        .ready(ready),
        .tx(link.tx)
    );
endmodule

// File: tb/tb_packet_transmitter.sv
// tb_packet_transmitter: directed checks of binary and ASCII packet streams, drops, checksum and reset.
module tb_packet_transmitter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    int drop_cnt = 0;
    logic [7:0] rx [40];
    int rx_err;
    logic rx_busy_ok, rx_done_pre, rx_done_at, rx_busy_at;
    logic [7:0] exp_bin [18];
    string exp_asc;

    packet_transmitter_if #(.PAYLOAD_SIZE(16)) bin_if ();
    packet_transmitter_if #(.PAYLOAD_SIZE(16)) asc_if ();

    packet_transmitter #(.PAYLOAD_SIZE(16), .CLK_FREQUENCY(8), .BAUD_RATE(1), .BINARY(1'b1)) dut_bin (
        .clk(clk), .reset(reset), .link(bin_if)
    );
    packet_transmitter #(.PAYLOAD_SIZE(16), .CLK_FREQUENCY(8), .BAUD_RATE(1), .BINARY(1'b0)) dut_asc (
        .clk(clk), .reset(reset), .link(asc_if)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (bin_if.dropped) drop_cnt++;

    function automatic logic txv(input bit a); return a ? asc_if.tx : bin_if.tx; endfunction
    function automatic logic busyv(input bit a); return a ? asc_if.busy : bin_if.busy; endfunction
    function automatic logic donev(input bit a); return a ? asc_if.done : bin_if.done; endfunction
    function automatic logic dropv(input bit a); return a ? asc_if.dropped : bin_if.dropped; endfunction

    // ends on the negedge of the first start-bit cycle
    task automatic start_pkt(input bit a);
        @(negedge clk);
        if (a) asc_if.start = 1'b1; else bin_if.start = 1'b1;
        @(negedge clk);
        if (a) asc_if.start = 1'b0; else bin_if.start = 1'b0;
    endtask

    // samples mid-bit of n back-to-back characters starting at the current start-bit cycle
    task automatic capture(input bit a, input int n);
        logic b;
        rx_err = 0;
        rx_busy_ok = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 10; j++) begin
                if (j > 0 || k > 0) repeat (8) @(negedge clk);
                b = txv(a);
                if (busyv(a) !== 1'b1) rx_busy_ok = 1'b0;
                if (j == 0) begin if (b !== 1'b0) rx_err++; end
                else if (j == 9) begin if (b !== 1'b1) rx_err++; end
                else rx[k][j-1] = b;
            end
        repeat (3) @(negedge clk);
        rx_done_pre = donev(a);
        @(negedge clk);
        rx_done_at = donev(a);
        rx_busy_at = busyv(a);
    endtask

    task automatic test_reset();
        bin_if.start = 1'b0;
        asc_if.start = 1'b0;
        bin_if.pulses = 16'h1234;
        asc_if.pulses = 16'h1234;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int a = 0; a < 2; a++) begin
            checks++;
            if ({txv(a[0]), busyv(a[0]), donev(a[0]), dropv(a[0])} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_hold[%0d] got %b exp 1000", a, {txv(a[0]), busyv(a[0]), donev(a[0]), dropv(a[0])});
            end
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int a = 0; a < 2; a++) begin
            checks++;
            if ({txv(a[0]), busyv(a[0]), donev(a[0]), dropv(a[0])} !== 4'b1000) begin
                failures++;
                $display("FAIL idle_after_reset[%0d] got %b exp 1000", a, {txv(a[0]), busyv(a[0]), donev(a[0]), dropv(a[0])});
            end
        end
    endtask

    task automatic test_binary();
        start_pkt(1'b0);
        checks++;
        if ({bin_if.tx, bin_if.busy} !== 2'b01) begin
            failures++;
            $display("FAIL bin_first_cycle tx,busy got %b exp 01", {bin_if.tx, bin_if.busy});
        end
        capture(1'b0, 18);
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (rx[i] !== exp_bin[i]) begin
                failures++;
                $display("FAIL bin_byte[%0d] got %h exp %h", i, rx[i], exp_bin[i]);
            end
        end
        checks++;
        if (rx_err !== 0 || rx_busy_ok !== 1'b1) begin
            failures++;
            $display("FAIL bin_framing errors=%0d busy_ok=%b exp 0/1", rx_err, rx_busy_ok);
        end
        checks++;
        if ({rx_done_pre, rx_done_at, rx_busy_at} !== 3'b010) begin
            failures++;
            $display("FAIL bin_done_1440 pre,done,busy got %b exp 010", {rx_done_pre, rx_done_at, rx_busy_at});
        end
    endtask

    // entered on the negedge of the done cycle
    task automatic test_back_to_back();
        logic [7:0] e [18];
        e = exp_bin;
        e[7] = 8'h01;
        bin_if.start = 1'b1;
        @(negedge clk);
        bin_if.start = 1'b0;
        checks++;
        if ({bin_if.tx, bin_if.busy, bin_if.dropped} !== 3'b010) begin
            failures++;
            $display("FAIL b2b_start tx,busy,dropped got %b exp 010", {bin_if.tx, bin_if.busy, bin_if.dropped});
        end
        capture(1'b0, 18);
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (rx[i] !== e[i]) begin
                failures++;
                $display("FAIL b2b_byte[%0d] got %h exp %h", i, rx[i], e[i]);
            end
        end
        checks++;
        if (rx_done_at !== 1'b1 || rx_err !== 0) begin
            failures++;
            $display("FAIL b2b_done done=%b errors=%0d exp 1/0", rx_done_at, rx_err);
        end
    endtask

    task automatic test_drop();
        logic [7:0] e [18];
        int d0;
        e = exp_bin;
        e[7] = 8'h02;
        repeat (5) @(negedge clk);
        d0 = drop_cnt;
        start_pkt(1'b0);
        fork
            capture(1'b0, 18);
            begin
                repeat (300) @(negedge clk);
                bin_if.start = 1'b1;
                bin_if.pulses = 16'hBEEF;
                @(negedge clk);
                bin_if.start = 1'b0;
                checks++;
                if ({bin_if.dropped, bin_if.busy} !== 2'b11) begin
                    failures++;
                    $display("FAIL drop_pulse dropped,busy got %b exp 11", {bin_if.dropped, bin_if.busy});
                end
            end
        join
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (rx[i] !== e[i]) begin
                failures++;
                $display("FAIL drop_byte[%0d] got %h exp %h", i, rx[i], e[i]);
            end
        end
        checks++;
        if (drop_cnt - d0 !== 1 || rx_busy_ok !== 1'b1) begin
            failures++;
            $display("FAIL drop_count got %0d busy_ok=%b exp 1/1", drop_cnt - d0, rx_busy_ok);
        end
    endtask

    task automatic test_checksum();
        bin_if.pulses = 16'hFFFF;
        repeat (5) @(negedge clk);
        start_pkt(1'b0);
        capture(1'b0, 18);
        checks++;
        if ({rx[7], rx[8], rx[9], rx[17]} !== 32'h03FFFFFE) begin
            failures++;
            $display("FAIL csum_ffff seq,pay,csum got %h exp 03fffffe", {rx[7], rx[8], rx[9], rx[17]});
        end
    endtask

    task automatic test_ascii();
        start_pkt(1'b1);
        checks++;
        if ({asc_if.tx, asc_if.busy} !== 2'b01) begin
            failures++;
            $display("FAIL asc_first_cycle tx,busy got %b exp 01", {asc_if.tx, asc_if.busy});
        end
        capture(1'b1, 38);
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (rx[i] !== exp_asc[i]) begin
                failures++;
                $display("FAIL asc_char[%0d] got %h exp %h", i, rx[i], exp_asc[i]);
            end
        end
        checks++;
        if ({rx[36], rx[37]} !== 16'h0D0A) begin
            failures++;
            $display("FAIL asc_eol got %h exp 0d0a", {rx[36], rx[37]});
        end
        checks++;
        if ({rx_done_pre, rx_done_at, rx_busy_at} !== 3'b010 || rx_err !== 0) begin
            failures++;
            $display("FAIL asc_done_3040 pre,done,busy got %b errors=%0d exp 010/0", {rx_done_pre, rx_done_at, rx_busy_at}, rx_err);
        end
    endtask

    task automatic test_reset_mid();
        bin_if.pulses = 16'h1234;
        repeat (5) @(negedge clk);
        start_pkt(1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (bin_if.tx !== 1'b0) begin
            failures++;
            $display("FAIL mid_bit_before_reset tx got %b exp 0", bin_if.tx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bin_if.tx, bin_if.busy, bin_if.done, bin_if.dropped} !== 4'b1000) begin
            failures++;
            $display("FAIL async_reset got %b exp 1000", {bin_if.tx, bin_if.busy, bin_if.done, bin_if.dropped});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        start_pkt(1'b0);
        capture(1'b0, 18);
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (rx[i] !== exp_bin[i]) begin
                failures++;
                $display("FAIL post_reset_byte[%0d] got %h exp %h", i, rx[i], exp_bin[i]);
            end
        end
    endtask

    initial begin
        exp_bin = '{8'hA5, 8'h5A, 8'hC3, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h46};
        exp_asc = {"A55AC3C3", "00000000", "1234", "00000000", "000000", "46"};
        test_reset();
        test_binary();
        test_back_to_back();
        test_drop();
        test_checksum();
        test_ascii();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
